// File: rtl/sram_bus_arbiter_if.sv
// Requester/bus bundle for sram_bus_arbiter.
// slave  : the arbiter's view (takes requests, drives the SRAM bus).
// master : the environment's view (pipeline requesters plus the SRAM).
interface sram_bus_arbiter_if;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        stallreq_if_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        stallreq_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;

  modport slave (
    input  flush_i, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_be_i,
           mem_addr_i, mem_wdata_i, bus_rdata_i,
    output if_rdata_o, if_ready_o, stallreq_if_o, mem_rdata_o, mem_ready_o,
           stallreq_mem_o, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o
  );

  modport master (
    output flush_i, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_be_i,
           mem_addr_i, mem_wdata_i, bus_rdata_i,
    input  if_rdata_o, if_ready_o, stallreq_if_o, mem_rdata_o, mem_ready_o,
           stallreq_mem_o, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Single-port SRAM bus arbiter between instruction fetch and data access.
// Data wins over fetch; each access holds the bus WAIT_CYCLES+1 cycles,
// then a one-cycle DONE state pulses the owner's ready.
// Optional macro ARB_FAIRNESS_EN: after FAIR_LIMIT consecutive data grants
// with a fetch waiting, the fetch is granted once.
module sram_bus_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int FAIR_LIMIT  = 4
) (
  input logic             clk,
  input logic             rst,
  sram_bus_arbiter_if.slave arb
);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic          owner_mem;
  logic          discard;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic          we_q;
  logic [31:0]   if_rdata_q, if_rdata_prev, mem_rdata_q;
  logic          any_req, grant_mem;

  assign any_req = arb.mem_req_i | arb.if_req_i;

`ifdef ARB_FAIRNESS_EN
  localparam int FW = ($clog2(FAIR_LIMIT + 1) < 3) ? 3 : $clog2(FAIR_LIMIT + 1);
  logic [FW-1:0] fair_cnt;

  // Data normally wins, except once the fetch has been starved FAIR_LIMIT times
  assign grant_mem = arb.mem_req_i &
                     ~(arb.if_req_i & (fair_cnt == FW'(FAIR_LIMIT)));

  // Count data grants made over a waiting fetch; any fetch grant or idle fetch clears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fair_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (grant_mem && arb.if_req_i) fair_cnt <= fair_cnt + 1'b1;
      else                           fair_cnt <= '0;
    end
  end
`else
  assign grant_mem = arb.mem_req_i;
`endif

  // Grant / bus-cycle / completion sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner_mem     <= 1'b0;
      discard       <= 1'b0;
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      if_rdata_q    <= '0;
      if_rdata_prev <= '0;
      mem_rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (any_req) begin
            owner_mem <= grant_mem;
            addr_q    <= grant_mem ? arb.mem_addr_i  : arb.if_addr_i;
            be_q      <= grant_mem ? arb.mem_be_i    : 4'b1111;
            we_q      <= grant_mem & arb.mem_we_i;
            wdata_q   <= grant_mem ? arb.mem_wdata_i : '0;
            cnt       <= CW'(WAIT_CYCLES);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_mem && arb.flush_i) discard <= 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            if (owner_mem) begin
              if (!we_q) mem_rdata_q <= arb.bus_rdata_i;
            end else if (!discard && !arb.flush_i) begin
              if_rdata_prev <= if_rdata_q;
              if_rdata_q    <= arb.bus_rdata_i;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          discard <= 1'b0;
          // A flush landing in the DONE cycle itself: the word was already
          // captured, so put the previous fetch result back
          if (!owner_mem && !discard && arb.flush_i) if_rdata_q <= if_rdata_prev;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus drive comes straight from the latched request; ready is a decode of DONE
  always_comb begin
    arb.bus_req_o      = (state == BUSY);
    arb.bus_we_o       = we_q;
    arb.bus_be_o       = be_q;
    arb.bus_addr_o     = addr_q;
    arb.bus_wdata_o    = wdata_q;
    arb.if_rdata_o     = if_rdata_q;
    arb.mem_rdata_o    = mem_rdata_q;
    arb.if_ready_o     = (state == DONE) & ~owner_mem & ~discard & ~arb.flush_i;
    arb.mem_ready_o    = (state == DONE) & owner_mem;
    arb.stallreq_if_o  = arb.if_req_i  & ~arb.if_ready_o;
    arb.stallreq_mem_o = arb.mem_req_i & ~arb.mem_ready_o;
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: transaction-timing model plus directed vectors.
module tb_sram_bus_arbiter;
  localparam int W  = 1;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  sram_bus_arbiter_if bif ();

  sram_bus_arbiter #(.WAIT_CYCLES(W), .FAIR_LIMIT(FL)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM contents as seen by the bus
  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    case (a)
      32'h80000000: return 32'h3C011234;
      32'hBFC00380: return 32'h24080001;
      32'h80400000: return 32'hCAFEF00D;
      default:      return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  always_comb bif.bus_rdata_i = rdata_for(bif.bus_addr_o);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- model: transaction timing from the grant cycle ----------------
  bit          m_active, m_mem, m_we, m_disc;
  int          m_t0;
  int          m_fair;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_if_prev, m_mem_rd;
  logic [3:0]  m_be;

  always @(negedge clk) begin
    int k;
    bit was_active, e_busy, e_done, e_ifr, e_memr, gm;
    if (!rst) begin
      m_active = 0; m_disc = 0; m_fair = 0;
      m_if_rd = '0; m_if_prev = '0; m_mem_rd = '0;
      chk("rst_bus_req",   bif.bus_req_o,   0);
      chk("rst_if_ready",  bif.if_ready_o,  0);
      chk("rst_mem_ready", bif.mem_ready_o, 0);
      chk("rst_if_rdata",  bif.if_rdata_o,  0);
      chk("rst_mem_rdata", bif.mem_rdata_o, 0);
      chk("rst_bus_addr",  bif.bus_addr_o,  0);
    end else begin
      k      = cyc - m_t0;
      e_busy = m_active && k <= W + 1;
      e_done = m_active && k == W + 2;
      e_ifr  = e_done && !m_mem && !m_disc && !bif.flush_i;
      e_memr = e_done && m_mem;
      chk("bus_req",   bif.bus_req_o,   32'(e_busy));
      chk("if_ready",  bif.if_ready_o,  32'(e_ifr));
      chk("mem_ready", bif.mem_ready_o, 32'(e_memr));
      chk("stall_if",  bif.stallreq_if_o,  32'(bif.if_req_i  & ~e_ifr));
      chk("stall_mem", bif.stallreq_mem_o, 32'(bif.mem_req_i & ~e_memr));
      chk("if_rdata",  bif.if_rdata_o,  m_if_rd);
      chk("mem_rdata", bif.mem_rdata_o, m_mem_rd);
      if (e_busy) begin
        chk("bus_addr", bif.bus_addr_o, m_addr);
        chk("bus_we",   bif.bus_we_o,   32'(m_we));
        chk("bus_be",   bif.bus_be_o,   32'(m_be));
        if (m_mem && m_we) chk("bus_wdata", bif.bus_wdata_o, m_wdata);
      end
      was_active = m_active;
      if (e_done) begin
        if (!m_mem && !m_disc && bif.flush_i) m_if_rd = m_if_prev;
        m_active = 0;
        m_disc   = 0;
      end else if (m_active) begin
        if (!m_mem && bif.flush_i) m_disc = 1;
        if (k == W + 1) begin
          if (m_mem && !m_we) m_mem_rd = bif.bus_rdata_i;
          if (!m_mem && !m_disc) begin
            m_if_prev = m_if_rd;
            m_if_rd   = bif.bus_rdata_i;
          end
        end
      end
      if (!was_active && (bif.mem_req_i || bif.if_req_i)) begin
        gm = bif.mem_req_i;
`ifdef ARB_FAIRNESS_EN
        if (bif.mem_req_i && bif.if_req_i && m_fair == FL) gm = 0;
        m_fair = (gm && bif.if_req_i) ? m_fair + 1 : 0;
`endif
        m_mem    = gm;
        m_addr   = gm ? bif.mem_addr_i : bif.if_addr_i;
        m_be     = gm ? bif.mem_be_i : 4'b1111;
        m_we     = gm && bif.mem_we_i;
        m_wdata  = bif.mem_wdata_i;
        m_t0     = cyc;
        m_active = 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_rdy(input bit mem, input string nm, output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mem ? bif.mem_ready_o : bif.if_ready_o) begin
        c = cyc;
        return;
      end
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  int c0, c;
  bit owners[$];

  initial begin
    rst = 1'b0;
    bif.flush_i = 0; bif.if_req_i = 0; bif.if_addr_i = '0;
    bif.mem_req_i = 0; bif.mem_we_i = 0; bif.mem_be_i = '0;
    bif.mem_addr_i = '0; bif.mem_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_state_bus_req", bif.bus_req_o, 0);

    // Single fetch: ready three cycles after the request
    @(posedge clk); #1;
    c0 = cyc; bif.if_addr_i = 32'h80000000; bif.if_req_i = 1;
    @(posedge clk); #1 chk("t1_busreq_c1", bif.bus_req_o, 1);
    @(posedge clk); #1 chk("t1_busreq_c2", bif.bus_req_o, 1);
    wait_rdy(0, "t1", c);
    chk("t1_latency", c - c0, 3);
    chk("t1_rdata", bif.if_rdata_o, 32'h3C011234);
    chk("t1_stall_low", bif.stallreq_if_o, 0);
    @(posedge clk); #1 bif.if_req_i = 0;

    // Simultaneous requests: load first, fetch after the next idle cycle
    @(posedge clk); #1;
    c0 = cyc;
    bif.mem_addr_i = 32'h80400000; bif.mem_we_i = 0; bif.mem_be_i = 4'hF; bif.mem_req_i = 1;
    bif.if_addr_i = 32'h80000004; bif.if_req_i = 1;
    wait_rdy(1, "t2m", c);
    chk("t2_mem_latency", c - c0, 3);
    chk("t2_mem_rdata", bif.mem_rdata_o, 32'hCAFEF00D);
    chk("t2_if_still_stalled", bif.stallreq_if_o, 1);
    @(posedge clk); #1 bif.mem_req_i = 0;
    chk("t2_if_stall_idle", bif.stallreq_if_o, 1);
    wait_rdy(0, "t2i", c);
    chk("t2_if_latency", c - c0, 7);
    chk("t2_if_rdata", bif.if_rdata_o, 32'h25A5A5A1);
    @(posedge clk); #1 bif.if_req_i = 0;

    // Store: strobes held for both bus cycles, load data untouched
    @(posedge clk); #1;
    c0 = cyc;
    bif.mem_addr_i = 32'h80400010; bif.mem_we_i = 1; bif.mem_be_i = 4'b0011;
    bif.mem_wdata_i = 32'hDEADBEEF; bif.mem_req_i = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("t3_bus_we", bif.bus_we_o, 1);
      chk("t3_bus_be", bif.bus_be_o, 32'h3);
      chk("t3_bus_wdata", bif.bus_wdata_o, 32'hDEADBEEF);
    end
    wait_rdy(1, "t3", c);
    chk("t3_latency", c - c0, 3);
    chk("t3_mem_rdata_kept", bif.mem_rdata_o, 32'hCAFEF00D);
    @(posedge clk); #1 bif.mem_req_i = 0; bif.mem_we_i = 0;

    // Flush mid-fetch: no ready, old word kept, re-issued fetch completes
    @(posedge clk); #1;
    c0 = cyc; bif.if_addr_i = 32'h80001000; bif.if_req_i = 1;
    @(posedge clk); #1 bif.flush_i = 1; bif.if_addr_i = 32'hBFC00380;
    @(posedge clk); #1 bif.flush_i = 0;
    @(posedge clk); #1;
    chk("t4_suppressed_ready", bif.if_ready_o, 0);
    chk("t4_rdata_held", bif.if_rdata_o, 32'h25A5A5A1);
    wait_rdy(0, "t4", c);
    chk("t4_refetch_latency", c - c0, 7);
    chk("t4_refetch_rdata", bif.if_rdata_o, 32'h24080001);
    @(posedge clk); #1 bif.if_req_i = 0;

    // Reset during a bus cycle, then the held request restarts cleanly
    @(posedge clk); #1;
    bif.if_addr_i = 32'h80000000; bif.if_req_i = 1;
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("t5_bus_req_drop", bif.bus_req_o, 0);
    chk("t5_if_rdata_clr", bif.if_rdata_o, 0);
    chk("t5_mem_rdata_clr", bif.mem_rdata_o, 0);
    chk("t5_bus_addr_clr", bif.bus_addr_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    c0 = cyc;
    wait_rdy(0, "t5", c);
    chk("t5_latency", c - c0, 3);
    chk("t5_rdata", bif.if_rdata_o, 32'h3C011234);
    @(posedge clk); #1 bif.if_req_i = 0;

    // Both requesters saturating: grant order over five completions
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    bif.mem_addr_i = 32'h80400000; bif.mem_we_i = 0; bif.mem_be_i = 4'hF; bif.mem_req_i = 1;
    bif.if_addr_i = 32'h80000000; bif.if_req_i = 1;
    for (int i = 0; i < 100 && owners.size() < 5; i++) begin
      @(posedge clk); #1;
      if (bif.mem_ready_o) owners.push_back(1'b1);
      if (bif.if_ready_o)  owners.push_back(1'b0);
    end
    chk("t6_grant_count", owners.size(), 5);
    for (int i = 0; i < 5 && i < owners.size(); i++) begin
`ifdef ARB_FAIRNESS_EN
      chk($sformatf("t6_grant%0d_is_mem", i), 32'(owners[i]), (i == 4) ? 0 : 1);
`else
      chk($sformatf("t6_grant%0d_is_mem", i), 32'(owners[i]), 1);
`endif
    end
    @(posedge clk); #1 bif.mem_req_i = 0; bif.if_req_i = 0;
    repeat (6) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one single-port SRAM-style bus between the instruction-fetch (IF) requester and the data (MEM) requester.
- Runs a fixed-latency bus transaction for whichever requester it grants, returns read data with a one-cycle ready pulse, and drives per-requester stall requests into the pipeline controller.
- Data accesses win over instruction fetches.
- flush_i discards an in-flight fetch result without aborting the bus cycle.

Parameters:
- WAIT_CYCLES, 1, extra bus cycles per access; every transaction holds the bus for WAIT_CYCLES+1 cycles.
- FAIR_LIMIT, 4, consecutive data grants allowed while IF is waiting; only used with ARB_FAIRNESS_EN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush_i  in  1  pipeline flush (exception/ERET)
- if_req_i  in  1  fetch request; held until if_ready_o
- if_addr_i  in  32  fetch address, word aligned
- if_rdata_o  out  32  fetched word, registered
- if_ready_o  out  1  one-cycle pulse, if_rdata_o valid
- stallreq_if_o  out  1  if_req_i & ~if_ready_o
- mem_req_i  in  1  data request; held until mem_ready_o
- mem_we_i  in  1  1 = store
- mem_be_i  in  4  byte enables
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  store data
- mem_rdata_o  out  32  load data, registered
- mem_ready_o  out  1  one-cycle completion pulse (loads and stores)
- stallreq_mem_o  out  1  mem_req_i & ~mem_ready_o
- bus_req_o  out  1  bus access active
- bus_we_o  out  1  write strobe
- bus_be_o  out  4  byte enables
- bus_addr_o  out  32  address
- bus_wdata_o  out  32  write data
- bus_rdata_i  in  32  read data, valid in the last access cycle

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, every output and internal register 0, bus_req_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, owner selection:
  - If mem_req_i: owner=MEM.
  - Else if if_req_i: owner=IF.
  - Latch into bus registers: addr, be (IF uses 4'b1111), we (IF uses 0), wdata.
  - Load counter=WAIT_CYCLES; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - bus_req_o=1; bus_* outputs are stable from the latched registers for the whole state.
  - Counter decrements each cycle.
  - At counter==0: capture bus_rdata_i into the owner's rdata register (stores leave mem_rdata_o unchanged); go to DONE.
- DONE:
  - bus_req_o=0.
  - Pulse the owner's ready for exactly one cycle, then return to IDLE.
  - A new grant can be made no earlier than the following IDLE cycle.
- Latency:
  - Request seen in IDLE at cycle T → ready asserted at cycle T+WAIT_CYCLES+2.
  - Back-to-back accesses are spaced WAIT_CYCLES+3 cycles apart.
- Stall outputs: purely combinational per the port definitions. Each drops in the ready cycle so the stage advances on that edge.
- Flush handling:
  - flush_i while owner=IF in BUSY or DONE sets a discard flag.
  - The bus transaction completes, but if_ready_o is suppressed and if_rdata_o is not updated. The flag clears on return to IDLE.
  - flush_i has no effect on MEM-owned transactions or in IDLE.
- Requester duty: holding req low before ready is illegal except under flush_i. The arbiter does not sample request operands after the grant.
- Simultaneous requests in IDLE: MEM granted; IF stays stalled until the MEM transaction's DONE cycle passes.
- Reset mid-transaction: the FSM returns to IDLE immediately, bus_req_o drops asynchronously, and no ready is pulsed.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - A 3-bit-or-wider counter increments on each MEM grant made while if_req_i=1.
  - The counter clears on any IF grant or when if_req_i=0 at the grant decision.
  - When the counter == FAIR_LIMIT and both request, IF is granted instead of MEM.
- Undefined: strict MEM priority; the counter logic is absent.

Test Plan:
- WAIT_CYCLES=1, if_req_i=1, addr 0x80000000, bus_rdata_i=0x3C011234 → bus_req_o high for cycles 1–2, if_ready_o pulse at cycle 3, if_rdata_o=0x3C011234, stallreq_if_o low only in cycle 3.
- if_req_i and mem_req_i (load 0x80400000) both rise in the same cycle → MEM granted first, mem_ready_o at +3; IF granted next IDLE, if_ready_o at +7.
- Store mem_we_i=1, be=4'b0011, wdata 0xDEADBEEF → bus_we_o=1, bus_be_o=0011 for 2 cycles, mem_ready_o pulse, mem_rdata_o unchanged.
- flush_i pulse during IF BUSY → bus completes, no if_ready_o, if_rdata_o holds old value; the re-issued fetch to 0xBFC00380 completes normally.
- rst low during BUSY → bus_req_o=0 and all outputs 0 immediately; after release, a pending request restarts from IDLE with full latency.
- ARB_FAIRNESS_EN, FAIR_LIMIT=4, mem_req_i and if_req_i held high → grant sequence MEM,MEM,MEM,MEM,IF,…; without the macro, IF is never granted.
